// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns the UART byte stream into validated SYNC/DEST/LEN/payload frames and releases each payload as a handshaked stream.
// Ports: clk, rst_n (async, active-low); rx_data/rx_valid byte strobe from the receiver;
//        out_data/out_dest/out_valid/out_last/out_ready payload stream to the consumers;
//        frame_ok/frame_err one-cycle pulses, err_code cause of the last error, busy = not hunting.
// Build option: define UART_RX_CHECKSUM_EN to require a trailing XOR checksum byte (CSUM state, error 3).
module uart_rx_frame_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int NUM_DEST = 4,
  parameter int MAX_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter int TIMEOUT_BITS = 20,
  localparam int DEST_W = NUM_DEST > 1 ? $clog2(NUM_DEST) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [2:0]        err_code,
  output logic              busy
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int TO_CYCLES = BIT_CYCLES * TIMEOUT_BITS;
  localparam int GW = $clog2(TO_CYCLES + 1);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  typedef enum logic [2:0] {
    HUNT, DEST, LEN, PAYLOAD,
`ifdef UART_RX_CHECKSUM_EN
    CSUM,
`endif
    DRAIN
  } state_t;
`ifdef UART_RX_CHECKSUM_EN
  localparam state_t PAY_NXT = CSUM;
  logic [7:0] csum;
  logic bad_sum;
  assign bad_sum = rx_data != csum;
`else
  localparam state_t PAY_NXT = DRAIN;
`endif
  state_t state, state_nxt;
  logic [2:0] err_nxt;
  logic [GW-1:0] gap;
  logic [7:0] len, idx;
  logic [DEST_W-1:0] dest;
  logic [7:0] mem [MAX_LEN];
  logic timed, time_out, acc, last, hs, bad_dest, bad_len;
  assign timed = state != HUNT && state != DRAIN;
  // the timeout wins over a byte arriving in the same cycle, which is then discarded
  assign time_out = timed && gap == GW'(TO_CYCLES - 1);
  assign acc = rx_valid && !time_out;
  // idx is the write index while collecting and the read index while draining
  assign last = idx == len - 8'd1;
  assign hs = out_valid && out_ready;
  assign bad_dest = {1'b0, rx_data} >= 9'(NUM_DEST);
  assign bad_len = rx_data == 8'd0 || {1'b0, rx_data} > 9'(MAX_LEN);
  assign out_dest = dest;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    err_nxt = 3'd0;
    if (time_out) begin
      state_nxt = HUNT;
      err_nxt = 3'd4;
    end else if (rx_valid)
      case (state)
        HUNT: state_nxt = rx_data == SYNC_BYTE ? DEST : HUNT;
        DEST: begin
          state_nxt = bad_dest ? HUNT : LEN;
          err_nxt = bad_dest ? 3'd1 : 3'd0;
        end
        LEN: begin
          state_nxt = bad_len ? HUNT : PAYLOAD;
          err_nxt = bad_len ? 3'd2 : 3'd0;
        end
        PAYLOAD: state_nxt = last ? PAY_NXT : PAYLOAD;
`ifdef UART_RX_CHECKSUM_EN
        CSUM: begin
          state_nxt = bad_sum ? HUNT : DRAIN;
          err_nxt = bad_sum ? 3'd3 : 3'd0;
        end
`endif
        // the receiver cannot be stalled, so a byte during DRAIN is lost
        DRAIN: err_nxt = 3'd5;
        default: ;
      endcase
    if (hs && last) state_nxt = HUNT;
  end
  always_comb begin
    out_valid = state == DRAIN;
    out_last = out_valid && last;
    out_data = out_valid ? mem[idx[AW-1:0]] : 8'd0;
    busy = state != HUNT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gap <= '0;
      len <= '0;
      idx <= '0;
      dest <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 3'd0;
`ifdef UART_RX_CHECKSUM_EN
      csum <= 8'd0;
`endif
    end else begin
      gap <= timed && !rx_valid && !time_out ? gap + GW'(1) : '0;
      frame_ok <= hs && last;
      frame_err <= err_nxt != 3'd0;
      if (err_nxt != 3'd0) err_code <= err_nxt;
      if (acc && state == DEST && !bad_dest) dest <= rx_data[DEST_W-1:0];
      if (acc && state == LEN && !bad_len) begin
        len <= rx_data;
        idx <= 8'd0;
      end
      if ((acc && state == PAYLOAD) || hs) idx <= last ? 8'd0 : idx + 8'd1;
`ifdef UART_RX_CHECKSUM_EN
      if (acc && state == DEST) csum <= rx_data;
      if (acc && (state == LEN || state == PAYLOAD)) csum <= csum ^ rx_data;
`endif
    end
  always_ff @(posedge clk)
    if (acc && state == PAYLOAD) mem[idx[AW-1:0]] <= rx_data;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frames checked against a frame-level reference model.
module tb_uart_rx_frame_ctrl;
  localparam int CLK_FREQ = 2_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int NUM_DEST = 4;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT_BITS = 20;
  localparam int T = (CLK_FREQ / BAUD_RATE) * TIMEOUT_BITS;
  localparam logic [7:0] SYNC = 8'h55;
`ifdef UART_RX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic [7:0] out_data;
  logic [1:0] out_dest;
  logic out_valid, out_last, frame_ok, frame_err, busy;
  logic [2:0] err_code;
  int n_chk = 0;
  int n_err = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int last_err = 0;
  int vcyc = 0;
  int got_q[$];
  int exp_q[$];
  logic [7:0] fq[$];
  bit rnd_ready = 1'b0;
  logic hold = 1'b0;
  logic [7:0] hd = 8'd0;
  logic [1:0] hdst = 2'd0;

  uart_rx_frame_ctrl #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .NUM_DEST(NUM_DEST),
    .MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_dest(out_dest), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back((int'(out_dest) << 9) | (int'(out_last) << 8) | int'(out_data));
    if (out_valid) vcyc++;
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      last_err = int'(err_code);
    end
    if (hold && out_valid) begin
      check("hold_data", int'(out_data), int'(hd));
      check("hold_dest", int'(out_dest), int'(hdst));
    end
    hold = out_valid && !out_ready;
    hd = out_data;
    hdst = out_dest;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = $urandom_range(0, 3) != 0;
  end

  // Frame semantics: find SYNC, then DEST < NUM_DEST, 1 <= LEN <= MAX_LEN,
  // payload, optional XOR checksum; a stream that ends early times out.
  function automatic int predict();
    int i, d, n;
    logic [7:0] x;
    exp_q.delete();
    i = 0;
    while (i < fq.size() && fq[i] != SYNC) i++;
    if (i + 1 >= fq.size()) return 4;
    d = int'(fq[i+1]);
    if (d >= NUM_DEST) return 1;
    if (i + 2 >= fq.size()) return 4;
    n = int'(fq[i+2]);
    if (n == 0 || n > MAX_LEN) return 2;
    if (i + 3 + n + CS > fq.size()) return 4;
    x = fq[i+1] ^ fq[i+2];
    for (int k = 0; k < n; k++) x ^= fq[i+3+k];
    if (CS == 1) if (fq[i+3+n] != x) return 3;
    for (int k = 0; k < n; k++) exp_q.push_back((d << 9) | (int'(k == n - 1) << 8) | int'(fq[i+3+k]));
    return 0;
  endfunction

  task automatic clr();
    got_q.delete();
    ok_cnt = 0;
    err_cnt = 0;
    last_err = 0;
    vcyc = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3 * T) begin
      @(negedge clk);
      t++;
    end
    check("idle", int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_beats();
    check("n_beats", got_q.size(), exp_q.size());
    foreach (exp_q[i]) check("beat", i < got_q.size() ? got_q[i] : -1, exp_q[i]);
  endtask

  task automatic run_frame(input int gmax);
    int code;
    code = predict();
    clr();
    foreach (fq[i]) begin
      repeat ($urandom_range(0, gmax)) begin
        @(posedge clk);
        #1;
      end
      send(fq[i]);
    end
    @(negedge clk);
    check("valid_lat", int'(out_valid), int'(code == 0));
    check("err_lat", int'(frame_err), int'(code != 0 && code != 4));
    wait_idle();
    cmp_beats();
    check("ok_cnt", ok_cnt, int'(code == 0));
    check("err_cnt", err_cnt, int'(code != 0));
    if (code != 0) check("err_code", last_err, code);
  endtask

  task automatic rand_frame();
    int kind, d, n;
    logic [7:0] x;
    kind = int'($urandom_range(0, 5));
    fq.delete();
    repeat ($urandom_range(0, 2)) begin
      x = 8'($urandom_range(0, 255));
      fq.push_back(x == SYNC ? 8'h54 : x);
    end
    fq.push_back(SYNC);
    d = kind == 1 ? int'($urandom_range(NUM_DEST, 255)) : int'($urandom_range(0, NUM_DEST - 1));
    fq.push_back(8'(d));
    if (kind != 1) begin
      n = kind == 2 ? 0 : kind == 3 ? int'($urandom_range(MAX_LEN + 1, 255)) : int'($urandom_range(1, MAX_LEN));
      fq.push_back(8'(n));
      if (kind < 2 || kind > 3) begin
        x = 8'(d ^ n);
        for (int k = 0; k < n; k++) begin
          fq.push_back(8'($urandom_range(0, 255)));
          x ^= fq[fq.size() - 1];
        end
        if (CS == 1) fq.push_back(kind == 4 ? x ^ 8'($urandom_range(1, 255)) : x);
        if (kind == 5) repeat ($urandom_range(1, n)) void'(fq.pop_back());
      end
    end
    run_frame(3);
  endtask

  initial begin
    int t;
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_ok", int'(frame_ok), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_dest", int'(out_dest), 0);
    check("rst_code", int'(err_code), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    fq = {8'h55, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33};
    if (CS == 1) fq.push_back(8'h01);
    run_frame(0);
    check("tp_beat0", got_q.size() > 0 ? got_q[0] : -1, (2 << 9) | 'h11);
    check("tp_beat2", got_q.size() > 2 ? got_q[2] : -1, (2 << 9) | 256 | 'h33);
    check("drain_cycles", vcyc, 3);
`ifdef UART_RX_CHECKSUM_EN
    fq = {8'h55, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_frame(0);
    check("csum_code", last_err, 3);
    check("csum_no_valid", vcyc, 0);
    fq = {8'h55, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
    run_frame(0);
`endif
    fq = {8'h55, 8'h04};
    run_frame(0);
    check("hdr_dest", last_err, 1);
    fq = {8'h55, 8'h01, 8'h00};
    run_frame(0);
    check("hdr_len0", last_err, 2);
    fq = {8'h55, 8'h01, 8'h11};
    run_frame(0);
    check("hdr_len17", last_err, 2);
    clr();
    send(SYNC);
    send(8'h01);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_err && t < T + 20);
    check("to_cycles", t, T + 1);
    check("to_code", int'(err_code), 4);
    check("to_busy", int'(busy), 0);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    clr();
    fq = {8'h55, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33};
    if (CS == 1) fq.push_back(8'h01);
    void'(predict());
    foreach (fq[i]) send(fq[i]);
    repeat (100) @(negedge clk);
    check("bp_valid", int'(out_valid), 1);
    check("bp_data", int'(out_data), 'h11);
    check("bp_dest", int'(out_dest), 2);
    send(SYNC);
    @(negedge clk);
    check("ovr_err", int'(frame_err), 1);
    check("ovr_code", int'(err_code), 5);
    check("ovr_data", int'(out_data), 'h11);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    cmp_beats();
    check("ovr_ok", ok_cnt, 1);
    check("ovr_errs", err_cnt, 1);
    clr();
    fq = {8'h55, 8'h01, 8'h04, 8'haa, 8'hbb};
    foreach (fq[i]) send(fq[i]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_err", int'(frame_err), 0);
    check("arst_ok", int'(frame_ok), 0);
    check("arst_code", int'(err_code), 0);
    check("arst_data", int'(out_data), 0);
    check("arst_dest", int'(out_dest), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_pulses", ok_cnt + err_cnt, 0);
    fq = {8'h55, 8'h03, 8'h02, 8'h5a, 8'ha5};
    if (CS == 1) fq.push_back(8'h03 ^ 8'h02 ^ 8'h5a ^ 8'ha5);
    run_frame(0);
    rnd_ready = 1'b1;
    repeat (80) rand_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART receiver. It parses the receiver's byte stream into framed commands (sync, destination, length, payload, checksum) and buffers each payload. Only validated frames are released, as a handshaked stream tagged with a destination index, so a single serial link can be shared by up to NUM_DEST downstream consumers. Malformed, stalled or overrun frames are dropped and reported.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate. The bit period is BIT_CYCLES = CLK_FREQ/BAUD_RATE.
- NUM_DEST, 4: number of destinations. DEST_W = max(1, $clog2(NUM_DEST)).
- MAX_LEN, 16: maximum payload length in bytes, 1..255.
- SYNC_BYTE, 8'h55: start-of-frame marker.
- TIMEOUT_BITS, 20: allowed inter-byte gap, in bit periods.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  byte from the receiver.
- rx_valid  in  1  single-cycle strobe from the receiver; cannot be stalled.
- out_data  out  8  payload byte.
- out_dest  out  DEST_W  destination of the current frame.
- out_valid  out  1  out_data is valid.
- out_last  out  1  marks the final payload byte.
- out_ready  in  1  consumer accepts the byte.
- frame_ok  out  1  one-cycle pulse when a frame is fully delivered.
- frame_err  out  1  one-cycle pulse when a frame is dropped or a byte is lost.
- err_code  out  3  cause of the last error; holds its value until the next error.
- busy  out  1  high in any state other than HUNT.

## Operation
- States: HUNT, DEST, LEN, PAYLOAD, CSUM, DRAIN.
- HUNT:
  - A byte equal to SYNC_BYTE moves to DEST.
  - Any other byte is ignored silently.
- DEST:
  - Latch the destination and seed the checksum with it.
  - If the value is >= NUM_DEST: frame_err with code 1, return to HUNT.
- LEN:
  - If the value is 0 or > MAX_LEN: frame_err with code 2, return to HUNT.
  - Otherwise latch the length, XOR it into the checksum and clear the write index.
- PAYLOAD:
  - Each byte is written to buffer[index], XORed into the checksum, and the index increments.
  - After the byte at index len-1, go to CSUM.
- CSUM:
  - The checksum is the 8-bit XOR of the DEST, LEN and all payload bytes.
  - On a match, go to DRAIN.
  - On a mismatch: frame_err with code 3, return to HUNT.
- DRAIN:
  - Presents buffer[rd], out_dest and out_last (high when rd == len-1).
  - out_valid is high for the whole state.
  - A handshake (out_valid && out_ready) advances rd.
  - The handshake on the last byte returns to HUNT and pulses frame_ok in the next cycle.
  - out_data and out_dest are stable while out_valid is high and out_ready is low.
- Timeout:
  - Applies in DEST, LEN, PAYLOAD and CSUM.
  - The gap counter clears on every rx_valid.
  - When it reaches BIT_CYCLES*TIMEOUT_BITS: frame_err with code 4, return to HUNT.
- Overrun:
  - An rx_valid during DRAIN drops the byte and raises frame_err with code 5.
  - Draining continues; the dropped byte is never treated as a sync byte.
- Error codes: 0 none, 1 destination, 2 length, 3 checksum, 4 timeout, 5 overrun.
- An rx_valid in the same cycle a timeout fires is discarded, and the timeout wins.

## Timing
- Reset values:
  - State HUNT.
  - out_valid, out_last, frame_ok, frame_err and busy all 0.
  - out_data, out_dest and err_code all 0.
  - Counters and the checksum are 0.
- Reset mid-frame or mid-drain aborts immediately. No frame_ok or frame_err is issued, and buffer contents are don't-care.
- State changes on the clock edge where rx_valid is sampled.
- frame_err is registered: it pulses in the cycle after the offending byte or timeout.
- out_valid rises in the cycle after the accepted checksum byte. Without the checksum feature, it rises in the cycle after the last payload byte.
- Throughput: one byte per cycle when out_ready is held high. Drain latency is len cycles.

## Configuration
- UART_RX_CHECKSUM_EN defined:
  - The CSUM state and error code 3 exist.
  - A frame is SYNC, DEST, LEN, payload, CSUM.
- UART_RX_CHECKSUM_EN undefined:
  - No CSUM state and no checksum logic.
  - PAYLOAD goes directly to DRAIN.
  - A frame is SYNC, DEST, LEN, payload.
  - Error code 3 is never produced.

## Test plan
- Good frame, checksum on: bytes 55 02 03 11 22 33 01 -> out_dest=2; out_data 11, 22, 33; out_last on 33; one frame_ok; busy low afterwards.
- Bad checksum: bytes 55 02 03 11 22 33 00 -> frame_err with err_code=3; out_valid never asserted. A following good frame is delivered normally.
- Bad header with NUM_DEST=4, MAX_LEN=16:
  - DEST 04 -> err_code=1.
  - LEN 00 -> err_code=2.
  - LEN 11 (hex) -> err_code=2.
  - State returns to HUNT in every case.
- Timeout: bytes 55 01, then silence -> frame_err with err_code=4 exactly BIT_CYCLES*20 cycles after the second byte's strobe (plus 1 registered cycle).
- Backpressure and overrun:
  - Send a good frame, hold out_ready low for 100 cycles, then inject rx_valid -> err_code=5.
  - The held byte stays stable; after out_ready rises, all bytes are delivered and frame_ok pulses.
- Async reset asserted mid-PAYLOAD -> all outputs are at reset values immediately. A following good frame parses correctly.
